// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM encoding, default operand width,
// and one-hot/index conversion used by the arbiter and its round-robin picker.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StBusy  = 2'd2,
        StResp  = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned MaxReq       = 8;

    function automatic logic [MaxReq-1:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot      = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
        onehot_to_idx = 3'd0;
        for (int i = 0; i < int'(MaxReq); i++) begin
            if (oh[i]) onehot_to_idx = 3'(i);
        end
    endfunction

    // Index of the requester after idx, wrapping at n.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx, input int unsigned n);
        if ({29'd0, idx} + 32'd1 >= n) next_ptr = 3'd0;
        else                           next_ptr = idx + 3'd1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above rr_ptr, wrapping.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx,
    output logic             any
);

    int pos;

    always_comb begin
        any = 1'b0;
        idx = 3'd0;
        pos = 0;
        // Scan from the farthest position back to rr_ptr so the nearest hit is written last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            pos = (int'(rr_ptr) + k) % int'(N_REQ);
            if (req[pos]) begin
                any = 1'b1;
                idx = 3'(pos);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            gnt[i] = any && (idx == 3'(i));
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between N_REQ requesters; holds the
// winner's operands for the whole operation and returns the product with a one-cycle strobe.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] opa,
    input  logic [N_REQ*WIDTH-1:0] opb,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_prod,
    output logic                   busy,
    output logic                   mul_st,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic                   mul_idle,
    input  logic [2*WIDTH-1:0]     mul_prod
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [2:0]         pick_idx;
    logic               pick_any;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;

        case (state_q)
            StIdle: begin
                if (pick_any && mul_idle) begin
                    gnt_d   = pick_gnt;
                    a_d     = opa[pick_idx*WIDTH +: WIDTH];
                    b_d     = opb[pick_idx*WIDTH +: WIDTH];
                    state_d = StStart;
                end
            end
            StStart: state_d = StBusy;
            StBusy: begin
                // Operands stay frozen here: the multiplier re-reads them on every add step.
                if (mul_done) begin
                    prod_d   = mul_prod;
                    rr_ptr_d = next_ptr(onehot_to_idx(MaxReq'(gnt_q)), N_REQ);
                    state_d  = StResp;
                end
            end
            StResp: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_ptr_q <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = (state_q == StResp) ? gnt_q : '0;
    assign rsp_prod  = prod_q;
    assign busy      = (state_q != StIdle);
    assign mul_st    = (state_q == StStart);
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule
